// File: rtl/alarm_defs.sv
// Shared state encodings, tick limits and BCD helpers for the alarm controller.
package alarm_defs;

    typedef enum logic [2:0] {
        ST_CLOCK     = 3'd0,
        ST_SET_TIME  = 3'd1,
        ST_SET_ALARM = 3'd2,
        ST_LOADING   = 3'd3,
        ST_RINGING   = 3'd4,
        ST_SNOOZE    = 3'd5
    } state_t;

    localparam logic [5:0] RING_TICKS    = 6'd60;
    localparam logic [8:0] SNOOZE_TICKS  = 9'd300;
    localparam logic [5:0] TIMEOUT_TICKS = 6'd30;

    localparam logic [4:0] MAX_HOURS   = 5'd23;
    localparam logic [5:0] MAX_MINUTES = 6'd59;

    function automatic logic [4:0] bcd_to_hours(input logic [2:0] tens, input logic [3:0] units);
        return {2'b00, tens} * 5'd10 + {1'b0, units};
    endfunction

    function automatic logic [5:0] bcd_to_minutes(input logic [2:0] tens, input logic [3:0] units);
        return {3'b000, tens} * 6'd10 + {2'b00, units};
    endfunction

endpackage

// File: rtl/time_field_edit.sv
// Wrap-around increment/decrement of one time field (hours or minutes).
module time_field_edit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] max,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] next_value
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // NOTE: next_value gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_value = value;
        if (up) begin
            next_value = (value >= max) ? '0 : value + ONE;
        end else if (down) begin
            next_value = (value == '0 || value > max) ? max : value - ONE;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock control FSM: time/alarm setting, counter loading, ringing and snooze.
module alarm_controller
    import alarm_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic [2:0] hour_tens,
    input  logic [3:0] hour_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_units,
    output logic       counter_enable,
    output logic       counter_load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [4:0] edit_hours,
    output logic [5:0] edit_minutes,
    output logic       edit_field,
    output logic       alarm_armed,
    output logic       buzzer,
    output logic [2:0] mode
);

    state_t     state;
    state_t     next_state;

    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [5:0] ring_count;
    logic [5:0] timeout_count;
    logic [8:0] snooze_count;
    logic       match_prev;

    logic [4:0] live_hours;
    logic [5:0] live_minutes;
    logic [4:0] hours_next;
    logic [5:0] minutes_next;

    logic act_c, act_u, act_d, act_l, act_r, any_btn;
    logic match, trigger;
    logic timeout_hit, ring_done, snooze_done;

    // One action per clk: each button is masked by every higher-priority one.
    assign act_c   = btn_c;
    assign act_u   = btn_u & ~btn_c;
    assign act_d   = btn_d & ~btn_c & ~btn_u;
    assign act_l   = btn_l & ~btn_c & ~btn_u & ~btn_d;
    assign act_r   = btn_r & ~btn_c & ~btn_u & ~btn_d & ~btn_l;
    assign any_btn = btn_c | btn_u | btn_d | btn_l | btn_r;

    assign live_hours   = bcd_to_hours(hour_tens, hour_units);
    assign live_minutes = bcd_to_minutes(min_tens, min_units);

    assign match   = alarm_armed && (live_hours == alarm_hours) && (live_minutes == alarm_minutes);
    assign trigger = match && !match_prev && (state == ST_CLOCK);

    assign timeout_hit = tick_1hz && !any_btn && (timeout_count == TIMEOUT_TICKS - 6'd1);
    assign ring_done   = tick_1hz && !any_btn && (ring_count == RING_TICKS - 6'd1);
    assign snooze_done = tick_1hz && (snooze_count <= 9'd1);

    time_field_edit #(.WIDTH(5)) u_hours_edit (
        .value      (edit_hours),
        .max        (MAX_HOURS),
        .up         (act_u & ~edit_field),
        .down       (act_d & ~edit_field),
        .next_value (hours_next)
    );

    time_field_edit #(.WIDTH(6)) u_minutes_edit (
        .value      (edit_minutes),
        .max        (MAX_MINUTES),
        .up         (act_u & edit_field),
        .down       (act_d & edit_field),
        .next_value (minutes_next)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLOCK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLOCK: begin
                if (trigger)    next_state = ST_RINGING;
                else if (act_c) next_state = ST_SET_TIME;
                else if (act_l) next_state = ST_SET_ALARM;
            end
            ST_SET_TIME: begin
                if (act_c)            next_state = ST_LOADING;
                else if (timeout_hit) next_state = ST_CLOCK;
            end
            ST_SET_ALARM: begin
                if (act_c || timeout_hit) next_state = ST_CLOCK;
            end
            ST_LOADING: begin
                if (tick_1hz) next_state = ST_CLOCK;
            end
            ST_RINGING: begin
                if (act_c)          next_state = ST_CLOCK;
                else if (act_u)     next_state = ST_SNOOZE;
                else if (ring_done) next_state = ST_CLOCK;
            end
            ST_SNOOZE: begin
                if (act_c || act_d)   next_state = ST_CLOCK;
                else if (snooze_done) next_state = ST_RINGING;
            end
            default: next_state = ST_CLOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_hours    <= '0;
            load_minutes  <= '0;
            edit_hours    <= '0;
            edit_minutes  <= '0;
            edit_field    <= 1'b0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_armed   <= 1'b0;
            ring_count    <= '0;
            timeout_count <= '0;
            snooze_count  <= '0;
            match_prev    <= 1'b0;
        end else begin
            match_prev <= match;
            case (state)
                ST_CLOCK: begin
                    if (trigger) begin
                        ring_count <= '0;
                    end else if (act_c) begin
                        edit_hours    <= live_hours;
                        edit_minutes  <= live_minutes;
                        edit_field    <= 1'b0;
                        timeout_count <= '0;
                    end else if (act_l) begin
                        edit_hours    <= alarm_hours;
                        edit_minutes  <= alarm_minutes;
                        edit_field    <= 1'b0;
                        timeout_count <= '0;
                    end else if (act_d) begin
                        alarm_armed <= ~alarm_armed;
                    end
                end
                ST_SET_TIME, ST_SET_ALARM: begin
                    edit_hours   <= hours_next;
                    edit_minutes <= minutes_next;
                    if (act_l || act_r) edit_field <= ~edit_field;
                    if (any_btn)       timeout_count <= '0;
                    else if (tick_1hz) timeout_count <= timeout_count + 6'd1;
                    if (act_c) begin
                        if (state == ST_SET_TIME) begin
                            load_hours   <= edit_hours;
                            load_minutes <= edit_minutes;
                        end else begin
                            alarm_hours   <= edit_hours;
                            alarm_minutes <= edit_minutes;
                            alarm_armed   <= 1'b1;
                        end
                    end
                end
                ST_RINGING: begin
                    if (any_btn)       ring_count <= '0;
                    else if (tick_1hz) ring_count <= ring_count + 6'd1;
                    if (act_u) snooze_count <= SNOOZE_TICKS;
                end
                ST_SNOOZE: begin
                    if (tick_1hz)    snooze_count <= snooze_count - 9'd1;
                    if (snooze_done) ring_count <= '0;
                    if (act_d)       alarm_armed <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Remaining outputs are pure decodes of the state register.
    assign mode           = state;
    assign counter_enable = (state == ST_CLOCK) || (state == ST_RINGING) || (state == ST_SNOOZE);
    assign counter_load   = (state == ST_LOADING);
    assign buzzer         = (state == ST_RINGING);

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus a randomized run against a behavioural model.
module tb_alarm_controller;

    logic       clk, reset, tick_1hz;
    logic       btn_c, btn_u, btn_d, btn_l, btn_r;
    logic [2:0] hour_tens, min_tens;
    logic [3:0] hour_units, min_units;
    logic       counter_enable, counter_load, edit_field, alarm_armed, buzzer;
    logic [4:0] load_hours, edit_hours;
    logic [5:0] load_minutes, edit_minutes;
    logic [2:0] mode;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: modes 0 clock, 1 set time, 2 set alarm, 3 loading, 4 ringing, 5 snooze.
    int m_mode, m_eh, m_em, m_field, m_ah, m_am, m_armed, m_lh, m_lm;
    int m_idle, m_ring, m_snooze, m_prev;
    int live_h, live_m;

    alarm_controller dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .hour_tens(hour_tens), .hour_units(hour_units), .min_tens(min_tens), .min_units(min_units),
        .counter_enable(counter_enable), .counter_load(counter_load),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .edit_hours(edit_hours), .edit_minutes(edit_minutes), .edit_field(edit_field),
        .alarm_armed(alarm_armed), .buzzer(buzzer), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_eh = 0; m_em = 0; m_field = 0; m_ah = 0; m_am = 0; m_armed = 0;
        m_lh = 0; m_lm = 0; m_idle = 0; m_ring = 0; m_snooze = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit c, u, d, l, r, t);
        bit any, match, trig;
        int act;
        any = c | u | d | l | r;
        act = c ? 1 : u ? 2 : d ? 3 : l ? 4 : r ? 5 : 0;
        match = (m_armed != 0) && live_h == m_ah && live_m == m_am;
        trig = match && !m_prev && m_mode == 0;
        m_prev = match;
        case (m_mode)
            0: begin
                if (trig) begin m_mode = 4; m_ring = 0; end
                else if (act == 1) begin m_mode = 1; m_eh = live_h; m_em = live_m; m_field = 0; m_idle = 0; end
                else if (act == 4) begin m_mode = 2; m_eh = m_ah; m_em = m_am; m_field = 0; m_idle = 0; end
                else if (act == 3) m_armed = (m_armed == 0) ? 1 : 0;
            end
            1, 2: begin
                if (any) begin
                    m_idle = 0;
                    case (act)
                        1: if (m_mode == 1) begin m_lh = m_eh; m_lm = m_em; m_mode = 3; end
                           else begin m_ah = m_eh; m_am = m_em; m_armed = 1; m_mode = 0; end
                        2: if (m_field == 0) m_eh = (m_eh + 1) % 24; else m_em = (m_em + 1) % 60;
                        3: if (m_field == 0) m_eh = (m_eh + 23) % 24; else m_em = (m_em + 59) % 60;
                        default: m_field = 1 - m_field;
                    endcase
                end else if (t) begin
                    m_idle++;
                    if (m_idle == 30) m_mode = 0;
                end
            end
            3: if (t) m_mode = 0;
            4: begin
                if (act == 1) m_mode = 0;
                else if (act == 2) begin m_mode = 5; m_snooze = 300; end
                else if (any) m_ring = 0;
                else if (t) begin m_ring++; if (m_ring == 60) m_mode = 0; end
            end
            5: begin
                if (act == 1) m_mode = 0;
                else if (act == 3) begin m_armed = 0; m_mode = 0; end
                else if (t) begin
                    m_snooze--;
                    if (m_snooze == 0) begin m_mode = 4; m_ring = 0; end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic set_live(input int h, input int m);
        live_h = h; live_m = m;
        hour_tens = 3'(h / 10); hour_units = 4'(h % 10);
        min_tens = 3'(m / 10);  min_units = 4'(m % 10);
    endtask

    task automatic step(input bit c, u, d, l, r, t);
        btn_c = c; btn_u = u; btn_d = d; btn_l = l; btn_r = r; tick_1hz = t;
        @(posedge clk);
        model_step(c, u, d, l, r, t);
        #1;
        btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0; tick_1hz = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    // Arms the alarm at h:m from a freshly reset controller (stored alarm 00:00, live 00:00).
    task automatic set_alarm_to(input int h, input int m);
        step(0, 0, 0, 1, 0, 0);
        repeat (h) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (m) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        set_live(0, 0);
        do_reset();
        tests_run++; if (mode !== 3'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        tests_run++; if (counter_enable !== 1'b1 || counter_load !== 1'b0) begin tests_failed++;
            $display("FAIL reset_counter_ctl: got en=%b load=%b expected en=1 load=0", counter_enable, counter_load); end
        tests_run++; if ({load_hours, load_minutes, edit_hours, edit_minutes, edit_field} !== 23'd0) begin tests_failed++;
            $display("FAIL reset_regs: got load %0d:%0d edit %0d:%0d field %b expected all 0", load_hours, load_minutes, edit_hours, edit_minutes, edit_field); end
        tests_run++; if (alarm_armed !== 1'b0 || buzzer !== 1'b0) begin tests_failed++;
            $display("FAIL reset_alarm: got armed=%b buzzer=%b expected 0 0", alarm_armed, buzzer); end
    endtask

    task automatic test_set_time();
        set_live(0, 0);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (mode !== 3'd1 || counter_enable !== 1'b0) begin tests_failed++;
            $display("FAIL set_time_entry: got mode=%0d en=%b expected mode=1 en=0", mode, counter_enable); end
        repeat (3) step(0, 1, 0, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd3) begin tests_failed++; $display("FAIL set_time_hours: got %0d expected 3", edit_hours); end
        step(0, 0, 0, 0, 1, 0);
        tests_run++; if (edit_field !== 1'b1) begin tests_failed++; $display("FAIL set_time_field: got %b expected 1", edit_field); end
        step(0, 0, 1, 0, 0, 0);
        tests_run++; if (edit_minutes !== 6'd59) begin tests_failed++; $display("FAIL set_time_minutes: got %0d expected 59", edit_minutes); end
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (mode !== 3'd3 || counter_load !== 1'b1 || load_hours !== 5'd3 || load_minutes !== 6'd59) begin tests_failed++;
            $display("FAIL set_time_load: got mode=%0d load=%b %0d:%0d expected mode=3 load=1 3:59", mode, counter_load, load_hours, load_minutes); end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tests_run++; if (counter_load !== 1'b1) begin tests_failed++; $display("FAIL set_time_load_held: got %b expected 1", counter_load); end
        btn_c = 0; tick_1hz = 1'b1;
        #2;
        tests_run++; if (counter_load !== 1'b1) begin tests_failed++; $display("FAIL set_time_load_on_tick: got %b expected 1", counter_load); end
        tick_1hz = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        tests_run++; if (mode !== 3'd0 || counter_load !== 1'b0 || counter_enable !== 1'b1) begin tests_failed++;
            $display("FAIL set_time_exit: got mode=%0d load=%b en=%b expected 0 0 1", mode, counter_load, counter_enable); end
    endtask

    task automatic test_wrap();
        set_live(23, 0);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd23 || edit_minutes !== 6'd0) begin tests_failed++;
            $display("FAIL wrap_copy: got %0d:%0d expected 23:0", edit_hours, edit_minutes); end
        step(0, 1, 0, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd0) begin tests_failed++; $display("FAIL wrap_hours_up: got %0d expected 0", edit_hours); end
        step(0, 0, 1, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd23) begin tests_failed++; $display("FAIL wrap_hours_down: got %0d expected 23", edit_hours); end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        tests_run++; if (edit_minutes !== 6'd59) begin tests_failed++; $display("FAIL wrap_minutes_down: got %0d expected 59", edit_minutes); end
        step(0, 1, 0, 0, 0, 0);
        tests_run++; if (edit_minutes !== 6'd0) begin tests_failed++; $display("FAIL wrap_minutes_up: got %0d expected 0", edit_minutes); end
    endtask

    task automatic test_alarm();
        set_live(0, 0);
        do_reset();
        step(0, 0, 0, 1, 0, 0);
        tests_run++; if (mode !== 3'd2) begin tests_failed++; $display("FAIL alarm_entry: got %0d expected 2", mode); end
        repeat (7) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (30) step(0, 0, 1, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd7 || edit_minutes !== 6'd30) begin tests_failed++;
            $display("FAIL alarm_edit: got %0d:%0d expected 7:30", edit_hours, edit_minutes); end
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (mode !== 3'd0 || alarm_armed !== 1'b1) begin tests_failed++;
            $display("FAIL alarm_store: got mode=%0d armed=%b expected 0 1", mode, alarm_armed); end
        set_live(7, 29);
        step(0, 0, 0, 0, 0, 1);
        tests_run++; if (buzzer !== 1'b0) begin tests_failed++; $display("FAIL alarm_early: got buzzer=%b expected 0", buzzer); end
        set_live(7, 30);
        step(0, 0, 0, 0, 0, 1);
        tests_run++; if (buzzer !== 1'b1 || mode !== 3'd4) begin tests_failed++;
            $display("FAIL alarm_ring: got buzzer=%b mode=%0d expected 1 4", buzzer, mode); end
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (buzzer !== 1'b0 || mode !== 3'd0 || alarm_armed !== 1'b1) begin tests_failed++;
            $display("FAIL alarm_dismiss: got buzzer=%b mode=%0d armed=%b expected 0 0 1", buzzer, mode, alarm_armed); end
        repeat (5) step(0, 0, 0, 0, 0, 1);
        tests_run++; if (buzzer !== 1'b0) begin tests_failed++; $display("FAIL alarm_no_retrigger: got buzzer=%b expected 0", buzzer); end
    endtask

    task automatic test_snooze();
        set_live(0, 0);
        do_reset();
        set_alarm_to(7, 30);
        set_live(7, 29);
        step(0, 0, 0, 0, 0, 1);
        set_live(7, 30);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        tests_run++; if (buzzer !== 1'b0 || mode !== 3'd5) begin tests_failed++;
            $display("FAIL snooze_entry: got buzzer=%b mode=%0d expected 0 5", buzzer, mode); end
        for (int i = 1; i <= 300; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (i == 299) begin
                tests_run++; if (buzzer !== 1'b0) begin tests_failed++; $display("FAIL snooze_299: got buzzer=%b expected 0", buzzer); end
            end
        end
        tests_run++; if (buzzer !== 1'b1 || mode !== 3'd4) begin tests_failed++;
            $display("FAIL snooze_expire: got buzzer=%b mode=%0d expected 1 4", buzzer, mode); end
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (i == 59) begin
                tests_run++; if (buzzer !== 1'b1) begin tests_failed++; $display("FAIL ring_59: got buzzer=%b expected 1", buzzer); end
            end
        end
        tests_run++; if (buzzer !== 1'b0 || mode !== 3'd0) begin tests_failed++;
            $display("FAIL ring_timeout: got buzzer=%b mode=%0d expected 0 0", buzzer, mode); end
    endtask

    task automatic test_timeout_priority();
        set_live(10, 20);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        tests_run++; if (edit_hours !== 5'd11 || edit_minutes !== 6'd20) begin tests_failed++;
            $display("FAIL timeout_edit: got %0d:%0d expected 11:20", edit_hours, edit_minutes); end
        repeat (20) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        repeat (29) step(0, 0, 0, 0, 0, 1);
        tests_run++; if (mode !== 3'd1) begin tests_failed++; $display("FAIL timeout_restart: got mode=%0d expected 1", mode); end
        step(0, 0, 0, 0, 0, 1);
        tests_run++; if (mode !== 3'd0 || counter_load !== 1'b0 || load_hours !== 5'd0 || load_minutes !== 6'd0) begin tests_failed++;
            $display("FAIL timeout_exit: got mode=%0d load=%b %0d:%0d expected 0 0 0:0", mode, counter_load, load_hours, load_minutes); end
        set_live(0, 0);
        do_reset();
        set_alarm_to(1, 0);
        set_live(1, 0);
        step(0, 0, 0, 0, 0, 1);
        tests_run++; if (buzzer !== 1'b1) begin tests_failed++; $display("FAIL priority_ring: got buzzer=%b expected 1", buzzer); end
        step(1, 1, 0, 0, 0, 0);
        tests_run++; if (mode !== 3'd0 || buzzer !== 1'b0) begin tests_failed++;
            $display("FAIL priority_c_wins: got mode=%0d buzzer=%b expected 0 0", mode, buzzer); end
    endtask

    task automatic test_reset_in_loading();
        set_live(5, 6);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (counter_load !== 1'b1) begin tests_failed++; $display("FAIL loading_reached: got %b expected 1", counter_load); end
        do_reset();
        tests_run++; if (counter_load !== 1'b0 || mode !== 3'd0 || load_hours !== 5'd0) begin tests_failed++;
            $display("FAIL reset_loading: got load=%b mode=%0d load_hours=%0d expected 0 0 0", counter_load, mode, load_hours); end
    endtask

    task automatic test_random();
        logic [29:0] got_v, exp_v;
        logic [4:0]  mask;
        int          sel;
        set_live(0, 0);
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            sel = int'($urandom % 64);
            if (sel == 0) set_live(int'($urandom % 24), int'($urandom % 60));
            else if (sel == 1) set_live(m_ah, m_am);
            sel = int'($urandom % 10);
            if (sel == 0) mask = 5'($urandom % 32);
            else if (sel < 3) mask = 5'd1 << ($urandom % 5);
            else mask = 5'd0;
            step(mask[4], mask[3], mask[2], mask[1], mask[0], ($urandom % 3) == 0);
            got_v = {mode, counter_enable, counter_load, load_hours, load_minutes,
                     edit_hours, edit_minutes, edit_field, alarm_armed, buzzer};
            exp_v = {3'(m_mode), (m_mode == 0 || m_mode == 4 || m_mode == 5), (m_mode == 3),
                     5'(m_lh), 6'(m_lm), 5'(m_eh), 6'(m_em), (m_field != 0), (m_armed != 0), (m_mode == 4)};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: got %h expected %h", cyc, got_v, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0; tick_1hz = 1'b0;
        btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
        set_live(0, 0);
        model_reset();
        #3;
        test_reset();
        test_set_time();
        test_wrap();
        test_alarm();
        test_snooze();
        test_timeout_priority();
        test_reset_in_loading();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 tick_1hz  in  1  one-clk pulse per second, aligned with the time-counter update.
REQ-005 btn_c, btn_u, btn_d, btn_l, btn_r  in  1 each  debounced one-clk button pulses.
REQ-006 hour_tens[2:0], hour_units[3:0], min_tens[2:0], min_units[3:0]  in  live BCD time from the system counter.
REQ-007 counter_enable  out  1  run enable to the system counter.
REQ-008 counter_load  out  1  load strobe to the system counter.
REQ-009 load_hours[4:0], load_minutes[5:0]  out  binary time to load (0-23, 0-59).
REQ-010 edit_hours[4:0], edit_minutes[5:0]  out  edit registers, for display while setting.
REQ-011 edit_field  out  1  0 = hours selected, 1 = minutes selected (for blink).
REQ-012 alarm_armed  out  1  alarm enabled.
REQ-013 buzzer  out  1  alarm sounding.
REQ-014 mode[2:0]  out  current state encoding.

Function
REQ-015 The FSM states SHALL be CLOCK=0, SET_TIME=1, SET_ALARM=2, LOADING=3, RINGING=4, SNOOZE=5; all other codes SHALL return to CLOCK on the next clk.
REQ-016 Button priority, one action per clk: c > u > d > l > r; lower-priority simultaneous pulses SHALL be dropped.
REQ-017 counter_enable SHALL be 1 in CLOCK, RINGING and SNOOZE, and 0 in SET_TIME, SET_ALARM and LOADING.
REQ-018 In CLOCK:
- btn_c -> SET_TIME, with edit regs copied from the live time converted to binary.
- btn_l -> SET_ALARM, with edit regs copied from the stored alarm.
- btn_d toggles alarm_armed.
- edit_field reset to 0 on either entry.
REQ-019 In SET_TIME and SET_ALARM:
- btn_l and btn_r toggle edit_field.
- btn_u increments the selected field; wrap hours 23->0, minutes 59->0.
- btn_d decrements the selected field; wrap hours 0->23, minutes 0->59.
REQ-020 In SET_TIME, btn_c SHALL copy the edit regs to load_hours/load_minutes and go to LOADING.
REQ-021 In LOADING, counter_load SHALL be 1 every clk, including the clk carrying the first tick_1hz; the FSM then goes to CLOCK; counter_load is 0 in all other states.
REQ-022 In SET_ALARM, btn_c SHALL store the edit regs as the alarm time, set alarm_armed=1, and go to CLOCK.
REQ-023 In SET_TIME and SET_ALARM, 30 consecutive tick_1hz with no button pulse SHALL return to CLOCK, discard the edits and leave the alarm unchanged; any button pulse restarts the count.
REQ-024 Alarm match = alarm_armed and live hours:minutes equal to the stored alarm.
- Only the rising edge of match (registered previous value) SHALL trigger.
- It triggers only in CLOCK; edges in any other state are lost.
- Trigger: go to RINGING, ring count = 0.
REQ-025 In RINGING, buzzer SHALL be 1:
- btn_c -> CLOCK (alarm stays armed).
- btn_u -> SNOOZE, snooze count = 300.
- 60 tick_1hz without a button -> CLOCK.
REQ-026 In SNOOZE, buzzer SHALL be 0:
- each tick_1hz decrements the snooze count; count reaching 0 -> RINGING, ring count = 0.
- btn_c -> CLOCK.
- btn_d clears alarm_armed and goes to CLOCK.
REQ-027 buzzer SHALL be 1 only in RINGING.
REQ-028 All outputs SHALL be registered or decoded from state only, with no combinational path from btn_* to outputs.

Reset
REQ-029 On a reset clk:
- mode=CLOCK, counter_enable=1, counter_load=0.
- load_*=0, edit_*=0, edit_field=0.
- alarm time 00:00, alarm_armed=0, buzzer=0.
- all tick counters and the match history = 0.
REQ-030 Reset SHALL override any in-progress edit, load, ring or snooze in that same clk.

Structure
REQ-031 State encodings and RING_TICKS=60, SNOOZE_TICKS=300, TIMEOUT_TICKS=30 SHALL live in a shared include alarm_defs.
REQ-032 Field wrap-around inc/dec SHALL be one sub-module, time_field_edit (inputs: value, max, up, down; output: next value), instanced for hours and minutes.
REQ-033 The snooze counter SHALL be 9 bits; the ring and timeout counters SHALL be 6 bits.

Verification
REQ-034 Set time: CLOCK, btn_c, btn_u x3 (hours 0->3), btn_r, btn_d (min 0->59), btn_c -> counter_load held until tick_1hz with load 03:59, then mode=CLOCK.
REQ-035 Wrap: edit hours=23, btn_u -> 0; minutes=0, btn_d -> 59.
REQ-036 Alarm: set alarm 07:30 and arm, drive live time 07:29 then 07:30 -> buzzer=1 on the clk after the change; holding 07:30 after btn_c dismiss gives no retrigger.
REQ-037 Snooze: RINGING, btn_u -> buzzer=0; after 300 ticks buzzer=1; then 60 ticks with no input -> CLOCK, buzzer=0.
REQ-038 Timeout/priority: SET_TIME idle 30 ticks -> CLOCK, no load; btn_c and btn_u in the same clk in RINGING -> CLOCK (c wins).
REQ-039 Reset during LOADING -> counter_load=0 and mode=CLOCK on the next clk.
